// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with status and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module fifo_sync_param #(
    parameter int D_WIDTH  = 32,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 2**ADDR_W - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               wr_en_i,
    input  logic [D_WIDTH-1:0] wr_data_i,
    input  logic               rd_en_i,
    output logic [D_WIDTH-1:0] rd_data_o,
    output logic               rd_valid_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               almost_full_o,
    output logic               almost_empty_o,
    output logic [ADDR_W:0]    count_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

    logic [D_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            push_ok, pop_ok;

    // Occupancy falls out of the wrap-bit pointers.
    assign count = wr_ptr_q - rd_ptr_q;

    assign count_o        = count;
    assign full_o         = (count == DEPTH_C);
    assign empty_o        = (count == '0);
    assign almost_full_o  = (count >= AF_C);
    assign almost_empty_o = (count <= AE_C);
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

    // Accept decisions from registered state; a full FIFO may push if it also pops.
    always_comb begin
        pop_ok  = rd_en_i & ~empty_o;
        push_ok = wr_en_i & (~full_o | pop_ok);
    end

    // Pointer and sticky-flag next state; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            ovf_d = ovf_q | (wr_en_i & ~push_ok);
            unf_d = unf_q | (rd_en_i & ~pop_ok);
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage write; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clr_i) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
        end
    end

`ifdef FIFO_FWFT_EN

    // Head word is always presented; rd_en_i only acknowledges it.
    always_comb begin
        rd_data_o  = mem_q[rd_ptr_q[ADDR_W-1:0]];
        rd_valid_o = ~empty_o;
    end

`else

    logic [D_WIDTH-1:0] rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;

    // Registered read: capture the head on an accepted pop, else hold data.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (!clr_i && pop_ok) begin
            rd_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
            rd_valid_d = 1'b1;
        end
    end

    // Read output register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

`endif

endmodule
